alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (with its internal control decode) between two requesters, e.g. the execute stage and a multi-cycle address/compare helper.
- Each requester uses a valid/ready request and response handshake.
- The block arbitrates round-robin and registers the operands driven into the ALU.
- It captures the ALU result and flags into a response register held until acknowledged, and keeps a saturating count of error responses.

Parameters:
- DATA_W, 32, operand/result width; must equal the ALU width.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- nrst  input  1  synchronous active-low reset
- req0_valid / req1_valid  input  1  requester k presents an operation
- req0_ready / req1_ready  output  1  request accepted this cycle
- req0_opcode / req1_opcode  input  7  instruction opcode
- req0_alu_op / req1_alu_op  input  3  funct3
- req0_func7 / req1_func7  input  7  funct7
- req0_opA, req0_opB / req1_opA, req1_opB  input  DATA_W  operands
- rsp0_valid / rsp1_valid  output  1  response available for requester k
- rsp0_ready / rsp1_ready  input  1  requester k consumes the response
- rsp_result  output  DATA_W  captured ALU result (shared; qualified by rspk_valid)
- rsp_flags  output  5  {ctrl_err, err, less, eq, zero} captured from ALU
- alu_opcode  output  7  to shared ALU
- alu_alu_op  output  3  to shared ALU
- alu_func7  output  7  to shared ALU
- alu_opA, alu_opB  output  DATA_W  to shared ALU
- alu_result  input  DATA_W  from ALU
- alu_zero, alu_eq, alu_less, alu_err, alu_ctrl_err  input  1  from ALU
- busy  output  1  state != IDLE
- err_count  output  ERRCNT_W  responses with err or ctrl_err set, saturating

Behaviour:
- Reset (nrst low at clk edge): state=IDLE, rr_ptr=0 (req0 priority), owner=0.
  - All operand registers, rsp_result, rsp_flags and err_count are 0.
  - rspk_valid=0, reqk_ready=0, busy=0.
  - Reset mid-operation abandons the transaction: no response is issued and the counter is cleared.
- FSM states IDLE, EXEC, RESP:
  - IDLE: grant goes to req[rr_ptr] if valid, else req[~rr_ptr] if valid, else none.
    - reqk_ready is combinational: 1 only in IDLE for the granted k. At most one ready per cycle; never ready outside IDLE.
    - On grant: capture opcode/alu_op/func7/opA/opB into operand registers, owner<=k, go to EXEC.
  - EXEC (exactly 1 cycle): the ALU sees the registered operands.
    - At the edge: rsp_result<=alu_result, rsp_flags<={alu_ctrl_err,alu_err,alu_less,alu_eq,alu_zero}, go to RESP.
    - err_count increments if alu_err|alu_ctrl_err and is not all-ones; it saturates at 2^ERRCNT_W-1.
  - RESP: rsp[owner]_valid=1. The other rsp_valid stays 0.
    - rsp_result/rsp_flags are stable while waiting. rsp_ready of the non-owner is ignored.
    - On rsp[owner]_ready: rr_ptr<=~owner, go to IDLE. rsp_valid drops in the next cycle.
- alu_* outputs always equal the operand registers. They change only on acceptance, so they are stable in EXEC and RESP.
- Latency: accept at edge N, rsp_valid high from cycle after edge N+1. Minimum 3 cycles per operation, including the IDLE accept cycle.
- Fairness: after serving k, ~k wins any simultaneous request. A requester waits at most one other operation.
- Branch operations: the ALU result may be X. rsp_result captures it as-is; consumers use rsp_flags only.
- Requests deasserted before acceptance have no effect. Operands need only be valid in the accept cycle.

Test Plan:
- After reset, req0 ADD (opcode 0110011, alu_op 000, func7 0000000, opA=5, opB=7), rsp0_ready=1 → req0_ready in cycle 0; rsp0_valid 2 cycles later with rsp_result=12, rsp_flags=00000.
- req1 SUB (func7 0100000, opA=opB=0x1234) → rsp_result=0, rsp_flags=00001 (zero); rsp0_valid stays 0 throughout.
- Both requesters valid continuously from reset → grant order req0, req1, req0, req1. No req_ready while busy; each grant comes 1 cycle after the previous response handshake.
- Hold rsp0_ready=0 for 4 cycles in RESP while req1_valid=1 → rsp0_valid, rsp_result and alu_opA stable; req1_ready=0 until rsp0_ready rises; req1 is granted the cycle after.
- Drive an opcode the ALU decodes as error → rsp_flags[3] or [4] set, err_count increments. With ERRCNT_W=2, 5 errors → err_count=3.
- Assert nrst=0 for one edge during EXEC → next cycle state IDLE, busy=0, rspk_valid=0, err_count=0. The next simultaneous requests grant req0 first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Registers the ALU operands and holds the captured result/flags until the owner acknowledges.
module alu_share_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [6:0]          req0_opcode,
    input  logic [2:0]          req0_alu_op,
    input  logic [6:0]          req0_func7,
    input  logic [DATA_W-1:0]   req0_opA,
    input  logic [DATA_W-1:0]   req0_opB,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [6:0]          req1_opcode,
    input  logic [2:0]          req1_alu_op,
    input  logic [6:0]          req1_func7,
    input  logic [DATA_W-1:0]   req1_opA,
    input  logic [DATA_W-1:0]   req1_opB,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [4:0]          rsp_flags,
    output logic [6:0]          alu_opcode,
    output logic [2:0]          alu_alu_op,
    output logic [6:0]          alu_func7,
    output logic [DATA_W-1:0]   alu_opA,
    output logic [DATA_W-1:0]   alu_opB,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    input  logic                alu_eq,
    input  logic                alu_less,
    input  logic                alu_err,
    input  logic                alu_ctrl_err,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, state_next;
    logic   rr_ptr;
    logic   owner;
    logic   grant0, grant1;
    logic   owner_ack;

    logic [6:0]        op_opcode;
    logic [2:0]        op_alu_op;
    logic [6:0]        op_func7;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        owner_ack  = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                // rr_ptr names the preferred requester; the other wins only when it is alone
                grant0     = req0_valid && (!rr_ptr || !req1_valid);
                grant1     = req1_valid && (rr_ptr || !req0_valid);
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                owner_ack  = owner ? rsp1_ready : rsp0_ready;
                if (owner_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            op_opcode  <= '0;
            op_alu_op  <= '0;
            op_func7   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            err_count  <= '0;
        end else begin
            if (grant1) begin
                op_opcode <= req1_opcode;
                op_alu_op <= req1_alu_op;
                op_func7  <= req1_func7;
                op_a      <= req1_opA;
                op_b      <= req1_opB;
                owner     <= 1'b1;
            end else if (grant0) begin
                op_opcode <= req0_opcode;
                op_alu_op <= req0_alu_op;
                op_func7  <= req0_func7;
                op_a      <= req0_opA;
                op_b      <= req0_opB;
                owner     <= 1'b0;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_ctrl_err, alu_err, alu_less, alu_eq, alu_zero};
                if ((alu_err || alu_ctrl_err) && (err_count != '1)) begin
                    err_count <= err_count + 1'b1;
                end
            end
            if (owner_ack) begin
                rr_ptr <= ~owner;
            end
        end
    end

    assign alu_opcode = op_opcode;
    assign alu_alu_op = op_alu_op;
    assign alu_func7  = op_func7;
    assign alu_opA    = op_a;
    assign alu_opB    = op_b;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU closing the loop.
module tb_alu_share_arbiter;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ERRCNT_W = 2;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b0000000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_BAD  = 7'b1111111;

    logic                clk;
    logic                nrst;
    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic [6:0]          req0_opcode, req1_opcode;
    logic [2:0]          req0_alu_op, req1_alu_op;
    logic [6:0]          req0_func7, req1_func7;
    logic [DATA_W-1:0]   req0_opA, req0_opB, req1_opA, req1_opB;
    logic                rsp0_valid, rsp1_valid;
    logic                rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic [4:0]          rsp_flags;
    logic [6:0]          alu_opcode;
    logic [2:0]          alu_alu_op;
    logic [6:0]          alu_func7;
    logic [DATA_W-1:0]   alu_opA, alu_opB;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero, alu_eq, alu_less, alu_err, alu_ctrl_err;
    logic                busy;
    logic [ERRCNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(
        .DATA_W  (DATA_W),
        .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_alu_op (req0_alu_op),
        .req0_func7  (req0_func7),
        .req0_opA    (req0_opA),
        .req0_opB    (req0_opB),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_alu_op (req1_alu_op),
        .req1_func7  (req1_func7),
        .req1_opA    (req1_opA),
        .req1_opB    (req1_opB),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .alu_opcode  (alu_opcode),
        .alu_alu_op  (alu_alu_op),
        .alu_func7   (alu_func7),
        .alu_opA     (alu_opA),
        .alu_opB     (alu_opB),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_eq      (alu_eq),
        .alu_less    (alu_less),
        .alu_err     (alu_err),
        .alu_ctrl_err(alu_ctrl_err),
        .busy        (busy),
        .err_count   (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural stand-in for the shared ALU: R-type ADD/SUB/AND, branch compares, error decode
    always_comb begin
        alu_result   = '0;
        alu_zero     = 1'b0;
        alu_eq       = 1'b0;
        alu_less     = 1'b0;
        alu_err      = 1'b0;
        alu_ctrl_err = 1'b0;
        case (alu_opcode)
            OPC_R: begin
                if (alu_alu_op == 3'b000 && alu_func7 == F7_ADD) begin
                    alu_result = alu_opA + alu_opB;
                    alu_zero   = (alu_result == '0);
                end else if (alu_alu_op == 3'b000 && alu_func7 == F7_SUB) begin
                    alu_result = alu_opA - alu_opB;
                    alu_zero   = (alu_result == '0);
                end else if (alu_alu_op == 3'b111 && alu_func7 == F7_ADD) begin
                    alu_result = alu_opA & alu_opB;
                    alu_zero   = (alu_result == '0);
                end else begin
                    alu_ctrl_err = 1'b1;
                end
            end
            OPC_BR: begin
                alu_result = 'x;
                alu_eq     = (alu_opA == alu_opB);
                alu_less   = ($signed(alu_opA) < $signed(alu_opB));
            end
            default: begin
                alu_err = 1'b1;
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete transaction on requester k; no comparisons, only bounded waits
    task automatic run_op(input int k, input logic [6:0] opc, input logic [2:0] aop,
                          input logic [6:0] f7, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, output logic [DATA_W-1:0] res,
                          output logic [4:0] flg, output bit ok);
        bit got;
        ok  = 1'b0;
        res = '0;
        flg = '0;
        if (k == 0) begin
            req0_valid = 1'b1; req0_opcode = opc; req0_alu_op = aop;
            req0_func7 = f7;   req0_opA = a;      req0_opB = b;
        end else begin
            req1_valid = 1'b1; req1_opcode = opc; req1_alu_op = aop;
            req1_func7 = f7;   req1_opA = a;      req1_opB = b;
        end
        #1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if ((k == 0 && req0_ready) || (k == 1 && req1_ready)) got = 1'b1;
            else step();
        end
        if (!got) return;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if ((k == 0 && rsp0_valid) || (k == 1 && rsp1_valid)) got = 1'b1;
            else step();
        end
        if (!got) return;
        res = rsp_result;
        flg = rsp_flags;
        if (k == 0) rsp0_ready = 1'b1;
        else rsp1_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opcode = '0; req0_alu_op = '0; req0_func7 = '0; req0_opA = '0; req0_opB = '0;
        req1_opcode = '0; req1_alu_op = '0; req1_func7 = '0; req1_opA = '0; req1_opB = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        step();
        nrst = 1'b1;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        checks++;
        if (rsp_result !== '0 || rsp_flags !== 5'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_regs got result %h flags %b errcnt %0d want 0 0 0",
                     rsp_result, rsp_flags, err_count);
        end
        checks++;
        if (alu_opA !== '0 || alu_opB !== '0 || alu_opcode !== 7'b0) begin
            errors++;
            $display("FAIL reset_operands got opA %h opB %h opc %b want 0",
                     alu_opA, alu_opB, alu_opcode);
        end
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_opcode = OPC_R; req0_alu_op = 3'b000;
        req0_func7 = F7_ADD; req0_opA = 32'd5; req0_opB = 32'd7;
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_accept got r0 %b r1 %b want 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec got busy %b rsp0 %b r0 %b want 1 0 0",
                     busy, rsp0_valid, req0_ready);
        end
        checks++;
        if (alu_opA !== 32'd5 || alu_opB !== 32'd7 || alu_opcode !== OPC_R) begin
            errors++;
            $display("FAIL add_alu_ops got %0d %0d want 5 7", alu_opA, alu_opB);
        end
        step();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd12
            || rsp_flags !== 5'b00000) begin
            errors++;
            $display("FAIL add_resp got v0 %b v1 %b res %0d flags %b want 1 0 12 00000",
                     rsp0_valid, rsp1_valid, rsp_result, rsp_flags);
        end
        step();
        rsp0_ready = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_done got v0 %b busy %b want 0 0", rsp0_valid, busy);
        end
    endtask

    task automatic test_sub();
        logic seen_rsp0;
        req1_valid = 1'b1; req1_opcode = OPC_R; req1_alu_op = 3'b000;
        req1_func7 = F7_SUB; req1_opA = 32'h1234; req1_opB = 32'h1234;
        rsp1_ready = 1'b1;
        seen_rsp0 = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL sub_accept got r1 %b r0 %b want 1 0", req1_ready, req0_ready);
        end
        step();
        req1_valid = 1'b0;
        seen_rsp0 = seen_rsp0 | rsp0_valid;
        step();
        seen_rsp0 = seen_rsp0 | rsp0_valid;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_flags !== 5'b00001) begin
            errors++;
            $display("FAIL sub_resp got v1 %b res %h flags %b want 1 0 00001",
                     rsp1_valid, rsp_result, rsp_flags);
        end
        step();
        seen_rsp0 = seen_rsp0 | rsp0_valid;
        rsp1_ready = 1'b0;
        checks++;
        if (seen_rsp0 !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_rsp0_quiet got seen_rsp0 %b v1 %b want 0 0", seen_rsp0, rsp1_valid);
        end
    endtask

    task automatic test_round_robin();
        int gk[4];
        int gc[4];
        int ng;
        int bad;
        ng = 0;
        bad = 0;
        req0_valid = 1'b1; req0_opcode = OPC_R; req0_alu_op = 3'b000;
        req0_func7 = F7_ADD; req0_opA = 32'd1; req0_opB = 32'd1;
        req1_valid = 1'b1; req1_opcode = OPC_R; req1_alu_op = 3'b000;
        req1_func7 = F7_ADD; req1_opA = 32'd2; req1_opB = 32'd2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            #1;
            if ((req0_ready && req1_ready) || ((req0_ready || req1_ready) && busy)) bad++;
            if (req0_ready || req1_ready) begin
                gk[ng] = req1_ready ? 1 : 0;
                gc[ng] = c;
                ng++;
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rr_ready_excl got %0d bad cycles want 0", bad);
        end
        checks++;
        if (ng != 4) begin
            errors++;
            $display("FAIL rr_timeout got %0d grants want 4", ng);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gk[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got req%0d want req%0d", i, gk[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (gc[i] - gc[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d] got %0d want 3", i, gc[i] - gc[i-1]);
                end
            end
        end
        for (int c = 0; c < 10 && busy; c++) step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain got busy %b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        req0_valid = 1'b1; req0_opcode = OPC_R; req0_alu_op = 3'b000;
        req0_func7 = F7_ADD; req0_opA = 32'd100; req0_opB = 32'd1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept got r0 %b want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_opcode = OPC_R; req1_alu_op = 3'b111;
        req1_func7 = F7_ADD; req1_opA = 32'hF0F0; req1_opB = 32'h0FF0;
        rsp1_ready = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd101
                || alu_opA !== 32'd100 || req1_ready !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || rsp0_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_ack_cycle got r1 %b v0 %b want 0 1", req1_ready, rsp0_valid);
        end
        step();
        rsp0_ready = 1'b0;
        checks++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_grant got r1 %b v0 %b want 1 0", req1_ready, rsp0_valid);
        end
        step();
        req1_valid = 1'b0;
        step();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_result !== 32'h00F0 || rsp_flags !== 5'b00000) begin
            errors++;
            $display("FAIL bp_req1_resp got v1 %b res %h flags %b want 1 000000f0 00000",
                     rsp1_valid, rsp_result, rsp_flags);
        end
        step();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_errors();
        logic [DATA_W-1:0] res;
        logic [4:0]        flg;
        bit                ok;
        logic [6:0]        opc;
        logic [6:0]        f7;
        logic [4:0]        want_f;
        int                want_c;
        for (int i = 1; i <= 5; i++) begin
            opc    = (i == 5) ? OPC_R : OPC_BAD;
            f7     = (i == 5) ? F7_BAD : F7_ADD;
            want_f = (i == 5) ? 5'b10000 : 5'b01000;
            want_c = (i < 3) ? i : 3;
            run_op(0, opc, 3'b000, f7, 32'd9, 32'd3, res, flg, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL err_op%0d_timeout got no handshake want handshake", i);
            end else if (flg !== want_f || int'(err_count) != want_c) begin
                errors++;
                $display("FAIL err_op%0d got flags %b count %0d want %b %0d",
                         i, flg, err_count, want_f, want_c);
            end
        end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_opcode = OPC_BAD; req0_alu_op = 3'b000;
        req0_func7 = F7_ADD; req0_opA = 32'd1; req0_opB = 32'd2;
        #1;
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_exec got busy %b want 1", busy);
        end
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL rst_mid_state got busy %b v0 %b v1 %b cnt %0d want 0 0 0 0",
                     busy, rsp0_valid, rsp1_valid, err_count);
        end
        step();
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_rsp got v0 %b busy %b want 0 0", rsp0_valid, busy);
        end
        req0_valid = 1'b1; req0_opcode = OPC_R; req0_func7 = F7_ADD;
        req1_valid = 1'b1; req1_opcode = OPC_R; req1_func7 = F7_ADD;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_prio got r0 %b r1 %b want 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        step();
        test_add();
        test_sub();
        test_round_robin();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end

endmodule
